fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
Instruction fetch/decode stage directly upstream of the micro-coded bit-serial execution core. Holds the PC and fetches one RV32I word at a time over a simple request/ready port. Decodes the word into the microprogram entry address, register indices, immediate, pc_reg and pc_plus4, then issues it with a one-cycle valid pulse. Waits for the core's done before updating the PC and fetching again; there is no overlap between instructions.

Parameters:
COLS, 32, datapath/instruction width (RV32; only 32 supported)
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
run  in  1  level; stage leaves IDLE while high
imem_req  out  1  fetch request, held until accepted
imem_addr  out  COLS  fetch address (current PC)
imem_rdata  in  COLS  instruction word, valid when imem_ready=1
imem_ready  in  1  fetch accept/data-valid
exec_done  in  1  execution core finished current instruction
redirect_valid  in  1  sampled with exec_done; take redirect_target
redirect_target  in  COLS  next PC for JALR/taken branch
decode_addr  out  5  microprogram entry code
id_rf_valid_inst  out  1  one-cycle issue pulse
rd_index  out  5  instr[11:7]
rs1_index  out  5  instr[19:15]
rs2_index  out  5  instr[24:20]
immediate  out  COLS  sign-extended immediate per format
pc_plus4  out  COLS  pc_reg+4
pc_reg  out  COLS  PC of issued instruction
halted  out  1  illegal instruction seen; sticky until reset

Behaviour:
- Reset (rst=0, async): state IDLE, PC=RESET_PC, all outputs 0 except imem_addr=RESET_PC, pc_reg=RESET_PC, pc_plus4=RESET_PC+4.
- FSM: IDLE -> FETCH when run=1. FETCH: imem_req=1, imem_addr=PC; on imem_ready=1 latch imem_rdata, go DECODE. DECODE (1 cycle): register all decoded fields; illegal -> HALT, else -> ISSUE. ISSUE: id_rf_valid_inst=1 for exactly one cycle -> WAIT. WAIT: on exec_done=1 compute next PC -> FETCH if run=1, else IDLE. HALT: halted=1, no further requests; exit only by reset.
- Fetch latency min 2 cycles (FETCH, DECODE) before ISSUE; imem_ready low holds FETCH indefinitely with imem_addr stable.
- Decoded outputs stable from ISSUE until the next DECODE; exec_done outside WAIT is ignored.
- Next PC: JAL -> pc_reg+J-imm (local adder); JALR/BRANCH -> redirect_target if redirect_valid with exec_done, else pc_reg+4; all others pc_reg+4. Arithmetic modulo 2^COLS (wraps silently); PC bits [1:0] forced 0.
- decode_addr map: 0 illegal; R-type ADD1 SUB2 SLL3 SLT4 SLTU5 XOR6 SRL7 SRA8 OR9 AND10; I-ALU ADDI11 SLTI12 SLTIU13 XORI14 ORI15 ANDI16 SLLI17 SRLI18 SRAI19; LW20 SW21 LUI22 AUIPC23 JAL24 JALR25 BRANCH26. Unlisted opcode/funct3/funct7 combinations and loads/stores other than word -> 0.
- Immediate: I/S/B/J sign-extended from bit 31; U = {instr[31:12],12'b0}; shifts = zero-extended shamt instr[24:20]; R-type = 0.
- Reset mid-FETCH/WAIT aborts immediately; the pending imem response and exec_done are discarded.

Decomposition:
- Package fd_pkg: state enum (IDLE, FETCH, DECODE, ISSUE, WAIT, HALT), RV32 opcode constants, decode_addr code constants (shared with micro_control ROM).
- Sub-module rv32_decoder: purely combinational instr -> {decode_addr, indices, immediate, is_jal, is_redirectable}; the FSM/PC logic stays in fetch_decode_stage.

Test Plan:
- Reset, run=1, imem_ready=1, rdata 0x00500093 -> imem_addr 0x0; ISSUE with decode_addr=11, rd=1, rs1=0, immediate=5, pc_reg=0, pc_plus4=4; after exec_done next imem_addr=0x4.
- rdata 0x402081B3 -> decode_addr=2, rd=3, rs1=1, rs2=2, immediate=0.
- pc 0x100, rdata 0x008000EF (JAL x1,+8) -> decode_addr=24, immediate=8, pc_plus4=0x104; next imem_addr=0x108.
- JALR issued, exec_done with redirect_valid=1, target 0x200 -> next imem_addr=0x200; same with redirect_valid=0 -> pc+4.
- imem_ready low 3 cycles -> imem_req held, imem_addr stable, no id_rf_valid_inst; rdata 0x00000000 -> halted=1, imem_req stays 0.
- Assert rst low during WAIT -> next cycle outputs at reset values, imem_addr=RESET_PC; a late exec_done is ignored.

Source files
------------

// File: rtl/fd_pkg.sv
// Shared types and constants for the fetch/decode stage: FSM states, RV32I opcodes
// and the microprogram entry codes that the micro_control ROM also indexes by.
package fd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    ISSUE,
    WAIT,
    HALT
  } fd_state_e;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [4:0] DA_ILLEGAL = 5'd0;
  localparam logic [4:0] DA_ADD     = 5'd1;
  localparam logic [4:0] DA_SUB     = 5'd2;
  localparam logic [4:0] DA_SLL     = 5'd3;
  localparam logic [4:0] DA_SLT     = 5'd4;
  localparam logic [4:0] DA_SLTU    = 5'd5;
  localparam logic [4:0] DA_XOR     = 5'd6;
  localparam logic [4:0] DA_SRL     = 5'd7;
  localparam logic [4:0] DA_SRA     = 5'd8;
  localparam logic [4:0] DA_OR      = 5'd9;
  localparam logic [4:0] DA_AND     = 5'd10;
  localparam logic [4:0] DA_ADDI    = 5'd11;
  localparam logic [4:0] DA_SLTI    = 5'd12;
  localparam logic [4:0] DA_SLTIU   = 5'd13;
  localparam logic [4:0] DA_XORI    = 5'd14;
  localparam logic [4:0] DA_ORI     = 5'd15;
  localparam logic [4:0] DA_ANDI    = 5'd16;
  localparam logic [4:0] DA_SLLI    = 5'd17;
  localparam logic [4:0] DA_SRLI    = 5'd18;
  localparam logic [4:0] DA_SRAI    = 5'd19;
  localparam logic [4:0] DA_LW      = 5'd20;
  localparam logic [4:0] DA_SW      = 5'd21;
  localparam logic [4:0] DA_LUI     = 5'd22;
  localparam logic [4:0] DA_AUIPC   = 5'd23;
  localparam logic [4:0] DA_JAL     = 5'd24;
  localparam logic [4:0] DA_JALR    = 5'd25;
  localparam logic [4:0] DA_BRANCH  = 5'd26;

  typedef struct packed {
    logic [4:0]  code;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        is_jal;
    logic        is_redirectable;
  } dec_t;

endpackage

// File: rtl/rv32_decoder.sv
// Combinational RV32I decoder: instruction word to microprogram entry code,
// register indices, format-selected immediate and next-PC class flags.
module rv32_decoder
  import fd_pkg::*;
(
  input  logic [31:0] instr,
  output dec_t        dec
);

  logic [6:0]  opcode;
  logic [6:0]  funct7;
  logic [2:0]  funct3;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
  logic [31:0] imm_u;
  logic [31:0] imm_sh;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};
  assign imm_sh = {27'b0, instr[24:20]};

  always_comb begin
    dec                 = '0;
    dec.rd              = instr[11:7];
    dec.rs1             = instr[19:15];
    dec.rs2             = instr[24:20];
    case (opcode)
      OP_REG: begin
        if (funct7 == F7_BASE) begin
          case (funct3)
            3'd0:    dec.code = DA_ADD;
            3'd1:    dec.code = DA_SLL;
            3'd2:    dec.code = DA_SLT;
            3'd3:    dec.code = DA_SLTU;
            3'd4:    dec.code = DA_XOR;
            3'd5:    dec.code = DA_SRL;
            3'd6:    dec.code = DA_OR;
            default: dec.code = DA_AND;
          endcase
        end else if (funct7 == F7_ALT && funct3 == 3'd0) begin
          dec.code = DA_SUB;
        end else if (funct7 == F7_ALT && funct3 == 3'd5) begin
          dec.code = DA_SRA;
        end
      end
      OP_IMM: begin
        dec.imm = imm_i;
        case (funct3)
          3'd0: dec.code = DA_ADDI;
          3'd2: dec.code = DA_SLTI;
          3'd3: dec.code = DA_SLTIU;
          3'd4: dec.code = DA_XORI;
          3'd6: dec.code = DA_ORI;
          3'd7: dec.code = DA_ANDI;
          3'd1: begin
            dec.imm = imm_sh;
            if (funct7 == F7_BASE) dec.code = DA_SLLI;
          end
          default: begin
            dec.imm = imm_sh;
            if (funct7 == F7_BASE)     dec.code = DA_SRLI;
            else if (funct7 == F7_ALT) dec.code = DA_SRAI;
          end
        endcase
      end
      OP_LOAD: begin
        dec.imm = imm_i;
        if (funct3 == 3'd2) dec.code = DA_LW;
      end
      OP_STORE: begin
        dec.imm = imm_s;
        if (funct3 == 3'd2) dec.code = DA_SW;
      end
      OP_LUI: begin
        dec.imm  = imm_u;
        dec.code = DA_LUI;
      end
      OP_AUIPC: begin
        dec.imm  = imm_u;
        dec.code = DA_AUIPC;
      end
      OP_JAL: begin
        dec.imm    = imm_j;
        dec.code   = DA_JAL;
        dec.is_jal = 1'b1;
      end
      OP_JALR: begin
        dec.imm = imm_i;
        if (funct3 == 3'd0) begin
          dec.code            = DA_JALR;
          dec.is_redirectable = 1'b1;
        end
      end
      OP_BRANCH: begin
        dec.imm = imm_b;
        if (funct3 != 3'd2 && funct3 != 3'd3) begin
          dec.code            = DA_BRANCH;
          dec.is_redirectable = 1'b1;
        end
      end
      default: dec.code = DA_ILLEGAL;
    endcase
    if (dec.code == DA_ILLEGAL) dec.imm = '0;
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Fetch/decode stage: fetches one word, decodes it, issues a one-cycle valid
// pulse, then waits for exec_done before computing the next PC. Only COLS=32.
module fetch_decode_stage
  import fd_pkg::*;
#(
  parameter int              COLS     = 32,
  parameter logic [COLS-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  output logic            imem_req,
  output logic [COLS-1:0] imem_addr,
  input  logic [COLS-1:0] imem_rdata,
  input  logic            imem_ready,
  input  logic            exec_done,
  input  logic            redirect_valid,
  input  logic [COLS-1:0] redirect_target,
  output logic [4:0]      decode_addr,
  output logic            id_rf_valid_inst,
  output logic [4:0]      rd_index,
  output logic [4:0]      rs1_index,
  output logic [4:0]      rs2_index,
  output logic [COLS-1:0] immediate,
  output logic [COLS-1:0] pc_plus4,
  output logic [COLS-1:0] pc_reg,
  output logic            halted
);

  // imem handshake: a word transfers on any cycle where imem_req and imem_ready
  // are both high; imem_req and imem_addr stay stable until that cycle.
  fd_state_e       state;
  logic [COLS-1:0] pc;
  logic [COLS-1:0] instr_q;
  logic            jal_q;
  logic            redir_q;
  logic [COLS-1:0] next_pc;
  dec_t            dec;

  rv32_decoder u_decoder (
    .instr (instr_q),
    .dec   (dec)
  );

  assign imem_addr = pc;

  always_comb begin
    next_pc = pc_plus4;
    if (jal_q)                         next_pc = pc_reg + immediate;
    else if (redir_q && redirect_valid) next_pc = redirect_target;
    next_pc[1:0] = 2'b00;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      instr_q          <= '0;
      jal_q            <= 1'b0;
      redir_q          <= 1'b0;
      imem_req         <= 1'b0;
      decode_addr      <= '0;
      id_rf_valid_inst <= 1'b0;
      rd_index         <= '0;
      rs1_index        <= '0;
      rs2_index        <= '0;
      immediate        <= '0;
      pc_reg           <= RESET_PC;
      pc_plus4         <= RESET_PC + COLS'(4);
      halted           <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (run) begin
            imem_req <= 1'b1;
            state    <= FETCH;
          end
        end
        FETCH: begin
          if (imem_ready) begin
            instr_q  <= imem_rdata;
            imem_req <= 1'b0;
            state    <= DECODE;
          end
        end
        DECODE: begin
          decode_addr <= dec.code;
          rd_index    <= dec.rd;
          rs1_index   <= dec.rs1;
          rs2_index   <= dec.rs2;
          immediate   <= dec.imm;
          jal_q       <= dec.is_jal;
          redir_q     <= dec.is_redirectable;
          pc_reg      <= pc;
          pc_plus4    <= pc + COLS'(4);
          if (dec.code == DA_ILLEGAL) begin
            halted <= 1'b1;
            state  <= HALT;
          end else begin
            id_rf_valid_inst <= 1'b1;
            state            <= ISSUE;
          end
        end
        ISSUE: begin
          id_rf_valid_inst <= 1'b0;
          state            <= WAIT;
        end
        WAIT: begin
          if (exec_done) begin
            pc <= next_pc;
            if (run) begin
              imem_req <= 1'b1;
              state    <= FETCH;
            end else begin
              state <= IDLE;
            end
          end
        end
        HALT:    state <= HALT;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: decode vector table, hand-built PC/stall/reset
// sequences, and random instructions built by an encoder-side reference model.
module tb_fetch_decode_stage;

  localparam int          COLS     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        run = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = '0;
  logic        imem_ready = 1'b0;
  logic        exec_done = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic [4:0]  decode_addr;
  logic        id_rf_valid_inst;
  logic [4:0]  rd_index;
  logic [4:0]  rs1_index;
  logic [4:0]  rs2_index;
  logic [31:0] immediate;
  logic [31:0] pc_plus4;
  logic [31:0] pc_reg;
  logic        halted;

  fetch_decode_stage #(.COLS(COLS), .RESET_PC(RESET_PC)) dut (
    .clk              (clk),
    .rst              (rst),
    .run              (run),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_rdata       (imem_rdata),
    .imem_ready       (imem_ready),
    .exec_done        (exec_done),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .decode_addr      (decode_addr),
    .id_rf_valid_inst (id_rf_valid_inst),
    .rd_index         (rd_index),
    .rs1_index        (rs1_index),
    .rs2_index        (rs2_index),
    .immediate        (immediate),
    .pc_plus4         (pc_plus4),
    .pc_reg           (pc_reg),
    .halted           (halted)
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] model_pc;

  typedef struct {
    logic [31:0] instr;
    logic [4:0]  code;
    logic [31:0] imm;
  } vec_t;

  logic [9:0] r_ops  [10] = '{{7'h00, 3'd0}, {7'h20, 3'd0}, {7'h00, 3'd1}, {7'h00, 3'd2},
                              {7'h00, 3'd3}, {7'h00, 3'd4}, {7'h00, 3'd5}, {7'h20, 3'd5},
                              {7'h00, 3'd6}, {7'h00, 3'd7}};
  logic [2:0] i_f3   [6]  = '{3'd0, 3'd2, 3'd3, 3'd4, 3'd6, 3'd7};
  logic [9:0] sh_ops [3]  = '{{7'h00, 3'd1}, {7'h00, 3'd5}, {7'h20, 3'd5}};
  logic [2:0] b_f3   [6]  = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    model_pc = RESET_PC;
  endtask

  // Drives one instruction end to end and advances the PC model.
  task automatic do_instr(input logic [31:0] instr, input logic [4:0] code, input logic [31:0] imm,
                          input int stall, input logic rv, input logic [31:0] tgt);
    int          budget;
    logic [31:0] nxt;
    budget = 0;
    while (!imem_req && budget < 20) begin
      tick();
      budget++;
    end
    chk("fetch_req", 32'(imem_req), 32'd1);
    chk("fetch_addr", imem_addr, model_pc);
    for (int i = 0; i < stall; i++) begin
      tick();
      chk("stall_req", 32'(imem_req), 32'd1);
      chk("stall_addr", imem_addr, model_pc);
      chk("stall_valid", 32'(id_rf_valid_inst), 32'd0);
    end
    imem_rdata = instr;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    imem_rdata = $urandom;
    chk("decode_req_low", 32'(imem_req), 32'd0);
    chk("decode_valid_low", 32'(id_rf_valid_inst), 32'd0);
    tick();
    if (code == 5'd0) begin
      chk("illegal_halted", 32'(halted), 32'd1);
      chk("illegal_valid", 32'(id_rf_valid_inst), 32'd0);
      chk("illegal_code", 32'(decode_addr), 32'd0);
      for (int i = 0; i < 3; i++) begin
        tick();
        chk("halt_req_low", 32'(imem_req), 32'd0);
        chk("halt_sticky", 32'(halted), 32'd1);
      end
      return;
    end
    chk("issue_valid", 32'(id_rf_valid_inst), 32'd1);
    chk("decode_addr", 32'(decode_addr), 32'(code));
    chk("rd_index", 32'(rd_index), 32'(instr[11:7]));
    chk("rs1_index", 32'(rs1_index), 32'(instr[19:15]));
    chk("rs2_index", 32'(rs2_index), 32'(instr[24:20]));
    chk("immediate", immediate, imm);
    chk("pc_reg", pc_reg, model_pc);
    chk("pc_plus4", pc_plus4, model_pc + 32'd4);
    chk("not_halted", 32'(halted), 32'd0);
    tick();
    chk("pulse_one_cycle", 32'(id_rf_valid_inst), 32'd0);
    for (int i = 0; i < int'($urandom_range(0, 2)); i++) tick();
    chk("wait_fields_stable", 32'(decode_addr), 32'(code));
    chk("wait_no_req", 32'(imem_req), 32'd0);
    exec_done       = 1'b1;
    redirect_valid  = rv;
    redirect_target = tgt;
    tick();
    exec_done      = 1'b0;
    redirect_valid = 1'b0;
    if (code == 5'd24)                            nxt = model_pc + imm;
    else if ((code == 5'd25 || code == 5'd26) && rv) nxt = tgt;
    else                                          nxt = model_pc + 32'd4;
    model_pc = nxt & 32'hFFFF_FFFC;
  endtask

  task automatic gen_random(output logic [31:0] instr, output logic [4:0] code,
                            output logic [31:0] imm);
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] v;
    int          sel;
    rd  = 5'($urandom_range(0, 31));
    rs1 = 5'($urandom_range(0, 31));
    rs2 = 5'($urandom_range(0, 31));
    v   = 32'($urandom_range(0, 4095)) - 32'd2048;
    case ($urandom_range(0, 9))
      0: begin
        sel   = int'($urandom_range(0, 9));
        instr = {r_ops[sel][9:3], rs2, rs1, r_ops[sel][2:0], rd, 7'b0110011};
        code  = 5'(sel + 1);
        imm   = 32'd0;
      end
      1: begin
        sel   = int'($urandom_range(0, 5));
        instr = {v[11:0], rs1, i_f3[sel], rd, 7'b0010011};
        code  = 5'(sel + 11);
        imm   = v;
      end
      2: begin
        sel   = int'($urandom_range(0, 2));
        instr = {sh_ops[sel][9:3], rs2, rs1, sh_ops[sel][2:0], rd, 7'b0010011};
        code  = 5'(sel + 17);
        imm   = 32'(rs2);
      end
      3: begin
        instr = {v[11:0], rs1, 3'd2, rd, 7'b0000011};
        code  = 5'd20;
        imm   = v;
      end
      4: begin
        instr = {v[11:5], rs2, rs1, 3'd2, v[4:0], 7'b0100011};
        code  = 5'd21;
        imm   = v;
      end
      5, 6: begin
        v     = $urandom;
        instr = {v[31:12], rd, (v[0] ? 7'b0110111 : 7'b0010111)};
        code  = v[0] ? 5'd22 : 5'd23;
        imm   = {v[31:12], 12'b0};
      end
      7: begin
        v     = (32'($urandom_range(0, 1048575)) - 32'd524288) * 32'd2;
        instr = {v[20], v[10:1], v[11], v[19:12], rd, 7'b1101111};
        code  = 5'd24;
        imm   = v;
      end
      8: begin
        instr = {v[11:0], rs1, 3'd0, rd, 7'b1100111};
        code  = 5'd25;
        imm   = v;
      end
      default: begin
        v     = v * 32'd2;
        sel   = int'($urandom_range(0, 5));
        instr = {v[12], v[10:5], rs2, rs1, b_f3[sel], v[4:1], v[11], 7'b1100011};
        code  = 5'd26;
        imm   = v;
      end
    endcase
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t        vecs[$];
    logic [31:0] r_instr;
    logic [4:0]  r_code;
    logic [31:0] r_imm;

    vecs.push_back(vec_t'{32'h00500093, 5'd11, 32'd5});
    vecs.push_back(vec_t'{32'h402081B3, 5'd2,  32'd0});
    vecs.push_back(vec_t'{32'h007302B3, 5'd1,  32'd0});
    vecs.push_back(vec_t'{32'h41F0D113, 5'd19, 32'd31});
    vecs.push_back(vec_t'{32'hFFF08093, 5'd11, 32'hFFFFFFFF});
    vecs.push_back(vec_t'{32'h12345537, 5'd22, 32'h12345000});
    vecs.push_back(vec_t'{32'hFE512E23, 5'd21, 32'hFFFFFFFC});
    vecs.push_back(vec_t'{32'h0081A203, 5'd20, 32'd8});
    vecs.push_back(vec_t'{32'h00819203, 5'd0,  32'd0});
    vecs.push_back(vec_t'{32'hFE208CE3, 5'd26, 32'hFFFFFFF8});
    vecs.push_back(vec_t'{32'h402091B3, 5'd0,  32'd0});
    vecs.push_back(vec_t'{32'hFFFFF097, 5'd23, 32'hFFFFF000});
    vecs.push_back(vec_t'{32'h80013093, 5'd13, 32'hFFFFF800});
    vecs.push_back(vec_t'{32'h0020A063, 5'd0,  32'd0});

    // Reset values
    rst = 1'b0;
    tick();
    tick();
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_addr", imem_addr, RESET_PC);
    chk("rst_pc_reg", pc_reg, RESET_PC);
    chk("rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    chk("rst_valid", 32'(id_rf_valid_inst), 32'd0);
    chk("rst_decode", 32'(decode_addr), 32'd0);
    chk("rst_imm", immediate, 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    rst = 1'b1;
    model_pc = RESET_PC;

    // Idle with run low; a stray exec_done has no effect
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    tick();
    chk("idle_no_req", 32'(imem_req), 32'd0);
    chk("idle_addr", imem_addr, RESET_PC);
    run = 1'b1;

    foreach (vecs[i]) begin
      do_instr(vecs[i].instr, vecs[i].code, vecs[i].imm, 0, 1'b0, 32'd0);
      if (vecs[i].code == 5'd0) do_reset();
    end

    // Redirects, JAL and a fetch stall
    do_instr(32'h00008067, 5'd25, 32'd0, 0, 1'b1, 32'h00000100);
    chk("redirect_pc", model_pc, 32'h00000100);
    do_instr(32'h008000EF, 5'd24, 32'd8, 0, 1'b0, 32'h0000DEAD);
    do_instr(32'h00008067, 5'd25, 32'd0, 0, 1'b0, 32'h00000500);
    do_instr(32'h00008067, 5'd25, 32'd0, 0, 1'b1, 32'h00000203);
    do_instr(32'h00500093, 5'd11, 32'd5, 3, 1'b0, 32'd0);

    // run low at exec_done returns to IDLE
    run = 1'b0;
    do_instr(32'h00500093, 5'd11, 32'd5, 0, 1'b0, 32'd0);
    tick();
    chk("run_low_idle_req", 32'(imem_req), 32'd0);
    chk("run_low_idle_addr", imem_addr, model_pc);
    run = 1'b1;

    for (int n = 0; n < 150; n++) begin
      gen_random(r_instr, r_code, r_imm);
      do_instr(r_instr, r_code, r_imm, int'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom);
    end

    // Asynchronous reset while waiting for exec_done
    do_instr(32'h00008067, 5'd25, 32'd0, 0, 1'b1, 32'h00000340);
    imem_rdata = 32'h00500093;
    imem_ready = 1'b1;
    tick();
    imem_ready = 1'b0;
    tick();
    tick();
    #2 rst = 1'b0;
    #1;
    chk("async_rst_addr", imem_addr, RESET_PC);
    chk("async_rst_pc_reg", pc_reg, RESET_PC);
    chk("async_rst_pc_plus4", pc_plus4, RESET_PC + 32'd4);
    chk("async_rst_decode", 32'(decode_addr), 32'd0);
    exec_done = 1'b1;
    run       = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    exec_done = 1'b0;
    tick();
    chk("late_done_no_req", 32'(imem_req), 32'd0);
    chk("late_done_addr", imem_addr, RESET_PC);
    model_pc = RESET_PC;
    run = 1'b1;
    do_instr(32'h00500093, 5'd11, 32'd5, 0, 1'b0, 32'd0);

    // Illegal all-zero word halts for good
    do_instr(32'h00000000, 5'd0, 32'd0, 0, 1'b0, 32'd0);
    exec_done = 1'b1;
    tick();
    exec_done = 1'b0;
    chk("halt_final_req", 32'(imem_req), 32'd0);
    chk("halt_final", 32'(halted), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
